// File: rtl/otp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otp_pkg
// Description : Shared definitions for the OTP command sequencer. Holds the
//               controller mode encodings, the sequencer state enum and small
//               helper functions used by the sequencer and its timer.
// Revision    : 1.0 - initial release
// ============================================================================
package otp_pkg;

   // Encodings presented to the OTP controller on the mode bus
   localparam logic [1:0] MODE_IDLE = 2'd0;
   localparam logic [1:0] MODE_PROG = 2'd1;
   localparam logic [1:0] MODE_READ = 2'd2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PROG   = 3'd1,
      VERIFY = 3'd2,
      READ   = 3'd3,
      RESP   = 3'd4
   } otp_state_e;

   // Controller mode implied by a sequencer state
   function automatic logic [1:0] state_mode(input otp_state_e st);
      case (st)
         PROG:         return MODE_PROG;
         VERIFY, READ: return MODE_READ;
         default:      return MODE_IDLE;
      endcase
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/otp_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : otp_seq_timer
// Description : Loadable down-counter with a zero flag. Load has priority
//               over decrement; the count saturates at zero.
// Ports       : clk          - clock, rising edge
//               reset        - synchronous, active-low
//               i_load       - load i_load_value this cycle
//               i_load_value - value to load
//               i_dec        - decrement by one (ignored at zero)
//               o_zero       - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module otp_seq_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/otp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : otp_cmd_sequencer
// Description : Accepts host read/program commands and sequences the OTP
//               controller: program windows of PROG_CYCLES, reads bounded by
//               RD_TIMEOUT, and a one-cycle response strobe per command.
//               Build option OTP_SEQ_VERIFY_EN adds read-back verify with up
//               to MAX_RETRY program attempts; without it a write completes
//               after a single program window.
// Ports       : clk, reset (sync, active-low)
//               host side : cmd_valid/cmd_ready/cmd_write/cmd_column/cmd_data,
//                           rsp_valid/rsp_data/rsp_error, busy
//               ctrl side : mode, column, data_in, writing_successful,
//                           read_active, data_out
// Revision    : 1.0 - initial release
// ============================================================================
module otp_cmd_sequencer
   import otp_pkg::*;
#(
   parameter int A           = 2,
   parameter int B           = 2,
   parameter int PROG_CYCLES = 16,
   parameter int MAX_RETRY   = 3,
   parameter int RD_TIMEOUT  = 32,
   parameter int ADDR_WIDTH  = $clog2(B)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_column,
   input  logic [A-1:0]          cmd_data,
   output logic                  rsp_valid,
   output logic [A-1:0]          rsp_data,
   output logic                  rsp_error,
   output logic                  busy,
   output logic [1:0]            mode,
   output logic [ADDR_WIDTH-1:0] column,
   output logic [A-1:0]          data_in,
   output logic                  writing_successful,
   input  logic                  read_active,
   input  logic [A-1:0]          data_out
);

   localparam int TW = $clog2(max_int(PROG_CYCLES, RD_TIMEOUT) + 1);
   // Timer is loaded with N-1 so the zero flag is seen on the Nth edge
   localparam logic [TW-1:0] c_prog_load = TW'(PROG_CYCLES - 1);
   localparam logic [TW-1:0] c_rd_load   = TW'(RD_TIMEOUT - 1);

   otp_state_e     r_state;
   otp_state_e     w_state_nxt;
   logic           r_seen_active;
   logic           w_seen_nxt;
   logic           w_tmr_load;
   logic [TW-1:0]  w_tmr_val;
   logic           w_tmr_dec;
   logic           w_tmr_zero;
   logic           w_rsp_set;
   logic           w_rsp_err_nxt;
   logic [A-1:0]   w_rsp_data_nxt;
   logic           w_ws_nxt;
   logic           w_hs;
   logic           w_rd_done;

`ifdef OTP_SEQ_VERIFY_EN
   localparam int AW = $clog2(MAX_RETRY + 1);
   logic [AW-1:0]  r_attempt;
   logic [AW-1:0]  w_attempt_nxt;
`else
   logic           w_unused_cfg;
   assign w_unused_cfg = (MAX_RETRY > 0);
`endif

   assign w_hs = cmd_valid & cmd_ready;
   // Read completes on the falling edge of read_active seen within this state
   assign w_rd_done = r_seen_active & ~read_active;

   otp_seq_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_tmr_load),
      .i_load_value (w_tmr_val),
      .i_dec        (w_tmr_dec),
      .o_zero       (w_tmr_zero)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_seen_nxt     = r_seen_active;
      w_tmr_load     = 1'b0;
      w_tmr_val      = c_prog_load;
      w_tmr_dec      = 1'b0;
      w_rsp_set      = 1'b0;
      w_rsp_err_nxt  = 1'b0;
      w_rsp_data_nxt = '0;
      w_ws_nxt       = 1'b0;
`ifdef OTP_SEQ_VERIFY_EN
      w_attempt_nxt  = r_attempt;
`endif
      case (r_state)
         IDLE: begin
            if (w_hs) begin
               w_seen_nxt = 1'b0;
               w_tmr_load = 1'b1;
               if (cmd_write) begin
                  w_state_nxt = PROG;
                  w_tmr_val   = c_prog_load;
`ifdef OTP_SEQ_VERIFY_EN
                  w_attempt_nxt = AW'(1);
`endif
               end else begin
                  w_state_nxt = READ;
                  w_tmr_val   = c_rd_load;
               end
            end
         end
         PROG: begin
            if (w_tmr_zero) begin
`ifdef OTP_SEQ_VERIFY_EN
               w_state_nxt = VERIFY;
               w_tmr_load  = 1'b1;
               w_tmr_val   = c_rd_load;
               w_seen_nxt  = 1'b0;
`else
               w_state_nxt    = RESP;
               w_rsp_set      = 1'b1;
               w_rsp_data_nxt = data_in;
               w_ws_nxt       = 1'b1;
`endif
            end else begin
               w_tmr_dec = 1'b1;
            end
         end
         READ: begin
            if (w_rd_done) begin
               w_state_nxt    = RESP;
               w_rsp_set      = 1'b1;
               w_rsp_data_nxt = data_out;
            end else if (w_tmr_zero) begin
               w_state_nxt   = RESP;
               w_rsp_set     = 1'b1;
               w_rsp_err_nxt = 1'b1;
            end else begin
               w_tmr_dec = 1'b1;
               if (read_active) w_seen_nxt = 1'b1;
            end
         end
`ifdef OTP_SEQ_VERIFY_EN
         VERIFY: begin
            if (w_rd_done) begin
               if (data_out == data_in) begin
                  w_state_nxt    = RESP;
                  w_rsp_set      = 1'b1;
                  w_rsp_data_nxt = data_out;
                  w_ws_nxt       = 1'b1;
               end else if (r_attempt < AW'(MAX_RETRY)) begin
                  w_state_nxt   = PROG;
                  w_attempt_nxt = r_attempt + 1'b1;
                  w_tmr_load    = 1'b1;
                  w_tmr_val     = c_prog_load;
               end else begin
                  w_state_nxt    = RESP;
                  w_rsp_set      = 1'b1;
                  w_rsp_err_nxt  = 1'b1;
                  w_rsp_data_nxt = data_out;
               end
            end else if (w_tmr_zero) begin
               w_state_nxt   = RESP;
               w_rsp_set     = 1'b1;
               w_rsp_err_nxt = 1'b1;
            end else begin
               w_tmr_dec = 1'b1;
               if (read_active) w_seen_nxt = 1'b1;
            end
         end
`endif
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they change with it
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state            <= IDLE;
         r_seen_active      <= 1'b0;
         cmd_ready          <= 1'b0;
         busy               <= 1'b0;
         mode               <= MODE_IDLE;
         rsp_valid          <= 1'b0;
         rsp_data           <= '0;
         rsp_error          <= 1'b0;
         writing_successful <= 1'b0;
         column             <= '0;
         data_in            <= '0;
`ifdef OTP_SEQ_VERIFY_EN
         r_attempt          <= '0;
`endif
      end else begin
         r_state            <= w_state_nxt;
         r_seen_active      <= w_seen_nxt;
         cmd_ready          <= (w_state_nxt == IDLE);
         busy               <= (w_state_nxt != IDLE);
         mode               <= state_mode(w_state_nxt);
         rsp_valid          <= w_rsp_set;
         writing_successful <= w_ws_nxt;
         if (w_rsp_set) begin
            rsp_data  <= w_rsp_data_nxt;
            rsp_error <= w_rsp_err_nxt;
         end
         if (w_hs) begin
            column  <= cmd_column;
            data_in <= cmd_data;
         end
`ifdef OTP_SEQ_VERIFY_EN
         r_attempt <= w_attempt_nxt;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_otp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_otp_cmd_sequencer
// Description : Directed self-checking bench for otp_cmd_sequencer with a
//               small reactive OTP controller model. Verify/retry scenarios
//               are exercised when OTP_SEQ_VERIFY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otp_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [0:0] cmd_column;
   logic [1:0] cmd_data;
   logic       rsp_valid;
   logic [1:0] rsp_data;
   logic       rsp_error;
   logic       busy;
   logic [1:0] mode;
   logic [0:0] column;
   logic [1:0] data_in;
   logic       writing_successful;
   logic       read_active = 1'b0;
   logic [1:0] data_out = 2'b00;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   otp_cmd_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_write          (cmd_write),
      .cmd_column         (cmd_column),
      .cmd_data           (cmd_data),
      .rsp_valid          (rsp_valid),
      .rsp_data           (rsp_data),
      .rsp_error          (rsp_error),
      .busy               (busy),
      .mode               (mode),
      .column             (column),
      .data_in            (data_in),
      .writing_successful (writing_successful),
      .read_active        (read_active),
      .data_out           (data_out)
   );

   // ---------------- controller model ----------------
   // Raises read_active for `lat` cycles once mode==2, then drops it while
   // presenting the next word from `words`. `stuck` keeps read_active low.
   logic [1:0] words [0:63];
   int         lat   = 3;
   logic       stuck = 1'b0;
   int         m_cnt = 0;
   logic       m_done = 1'b0;
   int         rd_idx = 0;

   always @(posedge clk) begin
      if (!reset || mode != 2'd2) begin
         read_active <= 1'b0;
         m_cnt       <= 0;
         m_done      <= 1'b0;
      end else if (!m_done && !stuck) begin
         if (m_cnt < lat) begin
            read_active <= 1'b1;
            m_cnt       <= m_cnt + 1;
         end else begin
            read_active <= 1'b0;
            data_out    <= words[rd_idx];
            m_done      <= 1'b1;
            rd_idx      <= rd_idx + 1;
         end
      end
   end

   // ---------------- activity monitor ----------------
   int         prog_cyc = 0;
   int         prog_win = 0;
   int         ws_cnt   = 0;
   int         rsp_cnt  = 0;
   logic [1:0] prev_mode = 2'd0;

   always @(negedge clk) begin
      if (mode == 2'd1) prog_cyc <= prog_cyc + 1;
      if (mode == 2'd1 && prev_mode != 2'd1) prog_win <= prog_win + 1;
      if (writing_successful) ws_cnt <= ws_cnt + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      prev_mode <= mode;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [0:0] col, input logic [1:0] d);
      cmd_valid  = 1'b1;
      cmd_write  = wr;
      cmd_column = col;
      cmd_data   = d;
      tick();
      cmd_valid  = 1'b0;
   endtask

   // Cycles from the handshake edge to the rsp_valid edge; -1 on timeout
   task automatic wait_rsp(input int budget, output int cyc);
      cyc = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (rsp_valid) begin
            cyc = i;
            break;
         end
      end
   endtask

   int cyc, p0, w0, ws0, r0;
   int wr_lat;

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_column = 1'b0;
      cmd_data   = 2'b00;
      for (int i = 0; i < 64; i++) words[i] = 2'b00;

      // ---- reset state ----
      repeat (3) tick();
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_mode", mode, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_ws", writing_successful, 0);
      reset = 1'b1;
      tick();
      check("rel_cmd_ready", cmd_ready, 1);
      check("rel_busy", busy, 0);

      // ---- read column 1, controller returns 2'b10 after 3 active cycles ----
      words[rd_idx] = 2'b10;
      lat = 3;
      issue(1'b0, 1'b1, 2'b00);
      check("rd_busy", busy, 1);
      check("rd_cmd_ready", cmd_ready, 0);
      check("rd_mode", mode, 2);
      check("rd_column", column, 1);
      wait_rsp(50, cyc);
      check("rd_latency", cyc, 5);
      check("rd_rsp_data", rsp_data, 2'b10);
      check("rd_rsp_error", rsp_error, 0);
      check("rd_resp_mode", mode, 0);
      tick();
      check("rd_rsp_pulse", rsp_valid, 0);
      check("rd_rsp_hold", rsp_data, 2'b10);
      check("rd_idle_ready", cmd_ready, 1);

      // ---- write column 0 data 2'b11, read-back matches ----
      words[rd_idx] = 2'b11;
      p0 = prog_cyc; w0 = prog_win; ws0 = ws_cnt;
      issue(1'b1, 1'b0, 2'b11);
      check("wr_mode", mode, 1);
      check("wr_column", column, 0);
      check("wr_data_in", data_in, 2'b11);
`ifdef OTP_SEQ_VERIFY_EN
      wr_lat = 21;
`else
      wr_lat = 16;
`endif
      wait_rsp(100, cyc);
      check("wr_latency", cyc, wr_lat);
      check("wr_rsp_error", rsp_error, 0);
      check("wr_rsp_data", rsp_data, 2'b11);
      check("wr_ws_with_rsp", writing_successful, 1);
      tick();
      check("wr_prog_cycles", prog_cyc - p0, 16);
      check("wr_prog_windows", prog_win - w0, 1);
      check("wr_ws_pulses", ws_cnt - ws0, 1);
      check("wr_idle_ready", cmd_ready, 1);

`ifdef OTP_SEQ_VERIFY_EN
      // ---- mismatch twice then match ----
      words[rd_idx]     = 2'b00;
      words[rd_idx + 1] = 2'b01;
      words[rd_idx + 2] = 2'b10;
      p0 = prog_cyc; w0 = prog_win; ws0 = ws_cnt;
      issue(1'b1, 1'b1, 2'b10);
      wait_rsp(200, cyc);
      check("retry_latency", cyc, 63);
      check("retry_rsp_error", rsp_error, 0);
      check("retry_rsp_data", rsp_data, 2'b10);
      tick();
      check("retry_windows", prog_win - w0, 3);
      check("retry_prog_cycles", prog_cyc - p0, 48);
      check("retry_ws_pulses", ws_cnt - ws0, 1);

      // ---- read-back always mismatches ----
      words[rd_idx]     = 2'b11;
      words[rd_idx + 1] = 2'b11;
      words[rd_idx + 2] = 2'b10;
      p0 = prog_cyc; w0 = prog_win; ws0 = ws_cnt;
      issue(1'b1, 1'b1, 2'b01);
      wait_rsp(200, cyc);
      check("fail_latency", cyc, 63);
      check("fail_rsp_error", rsp_error, 1);
      check("fail_rsp_data", rsp_data, 2'b10);
      tick();
      check("fail_windows", prog_win - w0, 3);
      check("fail_ws_pulses", ws_cnt - ws0, 0);
`endif

      // ---- read with read_active stuck low: timeout ----
      stuck = 1'b1;
      ws0 = ws_cnt;
      issue(1'b0, 1'b0, 2'b00);
      wait_rsp(60, cyc);
      check("to_latency", cyc, 32);
      check("to_rsp_error", rsp_error, 1);
      check("to_rsp_data", rsp_data, 0);
      tick();
      check("to_ws_pulses", ws_cnt - ws0, 0);
      check("to_idle_ready", cmd_ready, 1);
      stuck = 1'b0;

      // ---- reset during PROG aborts the write ----
      words[rd_idx] = 2'b01;
      r0 = rsp_cnt;
      issue(1'b1, 1'b1, 2'b01);
      repeat (5) tick();
      check("ab_mode_prog", mode, 1);
      reset = 1'b0;
      tick();
      check("ab_mode", mode, 0);
      check("ab_busy", busy, 0);
      check("ab_rsp_valid", rsp_valid, 0);
      check("ab_cmd_ready_in_rst", cmd_ready, 0);
      reset = 1'b1;
      tick();
      check("ab_cmd_ready", cmd_ready, 1);
      repeat (25) tick();
      check("ab_no_rsp", rsp_cnt - r0, 0);
      check("ab_mode_idle", mode, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/otp_cmd_sequencer.md
OTP_CMD_SEQUENCER -- requirements
Module: otp_cmd_sequencer

Interface
REQ-001 SHALL have parameter A, default 2: word width, i.e. rows per column.
REQ-002 SHALL have parameter B, default 2: number of columns; ADDR_WIDTH = $clog2(B).
REQ-003 SHALL have parameter PROG_CYCLES, default 16: cycles the program mode is held per attempt.
REQ-004 SHALL have parameter MAX_RETRY, default 3: maximum program attempts per write.
REQ-005 SHALL have parameter RD_TIMEOUT, default 32: cycles to wait for read completion.
REQ-006 SHALL have these ports:
  clk  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-low; asserted when 0.
  cmd_valid  in  1  host command offered.
  cmd_ready  out  1  sequencer accepts command.
  cmd_write  in  1  1 = program, 0 = read.
  cmd_column  in  ADDR_WIDTH  target column.
  cmd_data  in  A  program data.
  rsp_valid  out  1  one-cycle response strobe.
  rsp_data  out  A  read or verify data.
  rsp_error  out  1  retry or timeout failure.
  busy  out  1  command in progress.
  mode  out  2  to controller: 0 idle, 1 program, 2 read.
  column  out  ADDR_WIDTH  to controller.
  data_in  out  A  to controller, program data.
  writing_successful  out  1  to controller, ends the program attempt.
  read_active  in  1  from controller.
  data_out  in  A  from controller, read word.

Function
REQ-007 SHALL use states IDLE, PROG, VERIFY, READ, RESP.
REQ-008 SHALL drive cmd_ready = 1 only in IDLE; a handshake is cmd_valid & cmd_ready on a rising edge.
REQ-009 SHALL register cmd_column and cmd_data at the handshake and hold them unchanged on column and data_in until RESP.
REQ-010 SHALL, on a write handshake, enter PROG with the attempt count at 1 and drive mode = 1 for exactly PROG_CYCLES cycles.
REQ-011 SHALL, after PROG, enter VERIFY and drive mode = 2.
REQ-012 SHALL treat a read as complete when read_active is sampled 0 after having been sampled 1 in the same state.
REQ-013 SHALL capture data_out on the cycle the read completes.
REQ-014 SHALL, in VERIFY, on match (data_out == data_in): pulse writing_successful for 1 cycle, then go to RESP with rsp_error = 0.
REQ-015 SHALL, in VERIFY, on mismatch with attempt count < MAX_RETRY: increment the count and re-enter PROG.
REQ-016 SHALL, in VERIFY, on mismatch with attempt count == MAX_RETRY: go to RESP with rsp_error = 1.
REQ-017 SHALL, on a read handshake, enter READ, drive mode = 2, and go to RESP with the captured word once the read completes.
REQ-018 SHALL, in READ or VERIFY, go to RESP with rsp_error = 1 and rsp_data = 0 if the read has not completed within RD_TIMEOUT cycles.
REQ-019 SHALL, in RESP: assert rsp_valid for 1 cycle, drive mode = 0, and return to IDLE next cycle; the earliest next handshake is 1 cycle after rsp_valid.
REQ-020 SHALL keep rsp_data and rsp_error stable until the next rsp_valid.
REQ-021 SHALL drive busy = 1 in every state except IDLE.
REQ-022 SHALL drive mode = 0 in IDLE.
REQ-023 SHALL ignore cmd_valid while busy; no queuing.

Reset
REQ-024 SHALL, while reset = 0 at a clock edge, force state IDLE and all outputs to 0, except cmd_ready, which is 1 in IDLE after release.
REQ-025 SHALL, when reset is asserted mid-operation, abort it: mode = 0 next cycle, no rsp_valid, attempt count cleared.

Configuration
REQ-026 SHALL, with OTP_SEQ_VERIFY_EN defined, implement the VERIFY/retry path as above.
REQ-027 SHALL, without OTP_SEQ_VERIFY_EN, go from PROG to RESP after PROG_CYCLES and pulse writing_successful for 1 cycle.
REQ-028 SHALL, without OTP_SEQ_VERIFY_EN, report writes with rsp_error = 0 and rsp_data = data_in, with no readback and no retry counter.

Structure
REQ-029 SHALL take the mode encodings (MODE_IDLE/PROG/READ) and the state enum from shared package otp_pkg.
REQ-030 SHALL instantiate one sub-module otp_seq_timer (loadable down-counter with zero flag) for the PROG_CYCLES and RD_TIMEOUT counts.

Verification
REQ-031 SHALL cover: read col 1, model returns 2'b10 after 3 active cycles -> rsp_valid, rsp_data = 2'b10, rsp_error = 0.
REQ-032 SHALL cover: write col 0 data 2'b11, model reads back 2'b11 -> mode = 1 for 16 cycles, 1 writing_successful pulse, rsp_error = 0.
REQ-033 SHALL cover: write, readback mismatches twice then matches -> 3 PROG windows, rsp_error = 0.
REQ-034 SHALL cover: write, readback always mismatches -> 3 attempts, then rsp_error = 1 and no writing_successful pulse.
REQ-035 SHALL cover: read with read_active stuck 0 -> rsp_error = 1 after 32 cycles.
REQ-036 SHALL cover: reset = 0 during PROG -> mode = 0 next cycle, no rsp_valid, cmd_ready = 1 after release.
